// File: rtl/serial_add_arb.sv
// Bit-serial adder shared by two requesters under round-robin arbitration.
// One full-adder cell runs LSB-first for WIDTH cycles; the result is registered on entry to DONE.
module serial_add_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done,
    output logic             done_id
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } req_t;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, res, res_nxt;
    logic             c, c_nxt, s;
    logic             owner, last_gnt;
    logic             pick1;
    req_t             rq0, rq1, win_rq;

    assign rq0    = {a0, b0, cin0};
    assign rq1    = {a1, b1, cin1};
    // On a tie the requester not granted last time wins.
    assign pick1  = req1 & (~req0 | ~last_gnt);
    assign win_rq = pick1 ? rq1 : rq0;

    assign s     = a_sr[0] ^ b_sr[0] ^ c;
    assign c_nxt = (a_sr[0] & b_sr[0]) | (b_sr[0] & c) | (c & a_sr[0]);

    always_comb begin
        res_nxt = res >> 1;
        res_nxt[WIDTH-1] = s;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            c        <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        a_sr     <= win_rq.a;
                        b_sr     <= win_rq.b;
                        c        <= win_rq.cin;
                        owner    <= pick1;
                        last_gnt <= pick1;
                        gnt0     <= ~pick1;
                        gnt1     <= pick1;
                        cnt      <= '0;
                        state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c    <= c_nxt;
                    res  <= res_nxt;
                    cnt  <= cnt + CW'(1);
                    // Final bit: publish result so it is valid during DONE.
                    if (cnt == CNT_LAST) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        sum     <= res_nxt;
                        cout    <= c_nxt;
                        done_id <= owner;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arb.sv
// Bench for serial_add_arb: WIDTH=8 and WIDTH=1 instances, a transaction-level
// timing/arithmetic model compared every cycle, plus directed literal checks.
module tb_serial_add_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]      r0 = '0, r1 = '0, ci0 = '0, ci1 = '0;
    logic [1:0][7:0] a0p = '0, b0p = '0, a1p = '0, b1p = '0;
    logic [1:0]      g0, g1, bsy, dn, did, co;
    logic [7:0]      sum8;
    logic [0:0]      sum1;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    serial_add_arb #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst),
        .req0(r0[0]), .a0(a0p[0]), .b0(b0p[0]), .cin0(ci0[0]),
        .req1(r1[0]), .a1(a1p[0]), .b1(b1p[0]), .cin1(ci1[0]),
        .gnt0(g0[0]), .gnt1(g1[0]), .busy(bsy[0]), .sum(sum8), .cout(co[0]),
        .done(dn[0]), .done_id(did[0])
    );

    serial_add_arb #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst),
        .req0(r0[1]), .a0(a0p[1][0:0]), .b0(b0p[1][0:0]), .cin0(ci0[1]),
        .req1(r1[1]), .a1(a1p[1][0:0]), .b1(b1p[1][0:0]), .cin1(ci1[1]),
        .gnt0(g0[1]), .gnt1(g1[1]), .busy(bsy[1]), .sum(sum1), .cout(co[1]),
        .done(dn[1]), .done_id(did[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: an op is a phase count since capture; result is plain a+b+cin.
    int         ph[2];
    bit         lg[2], own[2], eid[2], ec[2];
    logic [7:0] es[2];
    logic [8:0] pend[2];

    function automatic int wid(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    function automatic logic [8:0] opv(input int k, input logic [7:0] v);
        return (k == 0) ? {1'b0, v} : {8'b0, v[0]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ph[k] = 0; lg[k] = 1'b1; es[k] = '0; ec[k] = 1'b0; eid[k] = 1'b0;
            end else if (ph[k] == 0) begin
                if (r0[k] || r1[k]) begin
                    own[k] = r1[k] && (!r0[k] || !lg[k]);
                    lg[k] = own[k];
                    pend[k] = own[k] ? opv(k, a1p[k]) + opv(k, b1p[k]) + {8'b0, ci1[k]}
                                     : opv(k, a0p[k]) + opv(k, b0p[k]) + {8'b0, ci0[k]};
                    ph[k] = 1;
                end
            end else if (ph[k] == wid(k) + 1) begin
                ph[k] = 0;
            end else begin
                ph[k]++;
                if (ph[k] == wid(k) + 1) begin
                    es[k]  = (k == 0) ? pend[k][7:0] : {7'b0, pend[k][0]};
                    ec[k]  = (k == 0) ? pend[k][8] : pend[k][1];
                    eid[k] = own[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                string p;
                p = (k == 0) ? "w8" : "w1";
                chk({p, ".gnt0"}, g0[k], (ph[k] == 1) && !own[k]);
                chk({p, ".gnt1"}, g1[k], (ph[k] == 1) && own[k]);
                chk({p, ".busy"}, bsy[k], ph[k] != 0);
                chk({p, ".done"}, dn[k], ph[k] == wid(k) + 1);
                chk({p, ".sum"}, (k == 0) ? sum8 : {7'b0, sum1}, es[k]);
                chk({p, ".cout"}, co[k], ec[k]);
                chk({p, ".done_id"}, did[k], eid[k]);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        r0 = '0; r1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {g0[0], g1[0]}, 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_result", {did[0], co[0], sum8}, 0);
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic do_op(input bit p, input logic [7:0] a, input logic [7:0] b,
                         input bit ci, input logic [8:0] expv);
        int n;
        bit ok;
        if (!p) begin a0p[0] = a; b0p[0] = b; ci0[0] = ci; r0[0] = 1'b1; end
        else    begin a1p[0] = a; b1p[0] = b; ci1[0] = ci; r1[0] = 1'b1; end
        ok = 0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clk); n++;
            if (p ? g1[0] : g0[0]) ok = 1;
        end
        chk("op_gnt_seen", ok, 1);
        chk("op_gnt_latency", n, 1);
        if (!p) r0[0] = 1'b0; else r1[0] = 1'b0;
        ok = 0; n = 0;
        while (!ok && n < 40) begin
            @(negedge clk); n++;
            chk("op_busy", bsy[0], 1);
            if (dn[0]) ok = 1;
        end
        chk("op_done_seen", ok, 1);
        chk("op_done_latency", n, 8);
        chk("op_result", {co[0], sum8}, expv);
        chk("op_done_id", did[0], p);
        @(negedge clk);
        chk("op_idle_busy", bsy[0], 0);
    endtask

    int gcnt[2], dcnt[2];
    int gseq[8], dseq[4], dt[4];

    initial begin
        int c, gi, nd, cyc;
        bit bad;
        do_reset();

        // 0x0F + 0x01 -> 0x10; also pins the model's own arithmetic.
        do_op(0, 8'h0F, 8'h01, 1'b0, 9'h010);
        chk("model_sum", es[0], 8'h10);
        do_op(1, 8'hFF, 8'h01, 1'b0, 9'h100);
        chk("model_cout", ec[0], 1);
        do_op(1, 8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // Contention: both held, each drops for one cycle after its grant.
        do_reset();
        a0p[0] = 8'h01; b0p[0] = 8'h02; ci0[0] = 0;
        a1p[0] = 8'h10; b1p[0] = 8'h20; ci1[0] = 1;
        r0[0] = 1'b1; r1[0] = 1'b1;
        gi = 0; nd = 0; cyc = 0;
        while (nd < 4 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (g0[0] && gi < 8) begin gseq[gi] = 0; gi++; end
            if (g1[0] && gi < 8) begin gseq[gi] = 1; gi++; end
            if (dn[0]) begin dseq[nd] = did[0]; dt[nd] = cyc; nd++; end
            r0[0] = !g0[0];
            r1[0] = !g1[0];
        end
        r0[0] = 1'b0; r1[0] = 1'b0;
        chk("cont_dones", nd, 4);
        chk("cont_grants", gi, 4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_gnt_order", gseq[i], i % 2);
            chk("cont_done_order", dseq[i], i % 2);
        end
        chk("cont_first_done", dt[0], 9);
        for (int i = 1; i < 4; i++) chk("cont_period", dt[i] - dt[i-1], 10);
        repeat (12) @(negedge clk);

        // req1 raised during a requester-0 op.
        do_reset();
        a0p[0] = 8'h11; b0p[0] = 8'h22; ci0[0] = 0;
        a1p[0] = 8'h20; b1p[0] = 8'h05; ci1[0] = 0;
        r0[0] = 1'b1;
        bad = 0;
        for (c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) begin chk("busy_gnt0", g0[0], 1); r0[0] = 1'b0; end
            if (c >= 3 && c <= 10 && g1[0]) bad = 1;
            if (c == 3) r1[0] = 1'b1;
            if (c == 9) chk("busy_done0", {dn[0], did[0], sum8}, {1'b1, 1'b0, 8'h33});
            if (c == 10) chk("busy_idle", bsy[0], 0);
            if (c == 11) begin chk("busy_gnt1_late", g1[0], 1); r1[0] = 1'b0; end
        end
        chk("busy_no_early_gnt1", bad, 0);
        repeat (9) @(negedge clk);
        chk("busy_op1_result", {co[0], sum8}, 9'h025);
        repeat (3) @(negedge clk);

        // Reset in ADD cycle 4 aborts without a done.
        a0p[0] = 8'h55; b0p[0] = 8'h66; ci0[0] = 1;
        r0[0] = 1'b1;
        for (c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) r0[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bsy[0], 0);
        chk("abort_result", {co[0], sum8}, 0);
        chk("abort_done", dn[0], 0);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin @(negedge clk); if (dn[0]) bad = 1; end
        chk("abort_no_done", bad, 0);
        do_op(0, 8'h03, 8'h04, 1'b0, 9'h007);

        // Randomized traffic on both widths.
        do_reset();
        gcnt = '{0, 0}; dcnt = '{0, 0};
        cyc = 0;
        while (gcnt[0] < 1000 && cyc < 40000) begin
            @(negedge clk); cyc++;
            for (int k = 0; k < 2; k++) begin
                if (g0[k]) gcnt[k]++;
                if (g1[k]) gcnt[k]++;
                if (dn[k]) dcnt[k]++;
                if (r0[k]) begin
                    if (g0[k]) r0[k] = 1'b0;
                end else begin
                    a0p[k] = 8'($urandom); b0p[k] = 8'($urandom); ci0[k] = 1'($urandom);
                    if ($urandom_range(3) == 0) r0[k] = 1'b1;
                end
                if (r1[k]) begin
                    if (g1[k]) r1[k] = 1'b0;
                end else begin
                    a1p[k] = 8'($urandom); b1p[k] = 8'($urandom); ci1[k] = 1'($urandom);
                    if ($urandom_range(3) == 0) r1[k] = 1'b1;
                end
            end
        end
        r0 = '0; r1 = '0;
        repeat (15) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (g0[k]) gcnt[k]++;
                if (g1[k]) gcnt[k]++;
                if (dn[k]) dcnt[k]++;
            end
        end
        chk("rand_ops_w8", gcnt[0] >= 1000, 1);
        chk("rand_done_per_gnt_w8", dcnt[0], gcnt[0]);
        chk("rand_done_per_gnt_w1", dcnt[1], gcnt[1]);
        chk("rand_ops_w1", gcnt[1] > 100, 1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
